// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, FSM state
// encodings, mux-select and ALU op-class codes, and the per-state control decode.
package multicycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    // Encodings 14 and 15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13
    } state_t;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    localparam logic [1:0] WB_ALUOUT    = 2'b00;
    localparam logic [1:0] WB_MDR       = 2'b01;
    localparam logic [1:0] WB_PC        = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_R     = 3'b000;
    localparam logic [2:0] ALU_I     = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_LW    = 3'b011;
    localparam logic [2:0] ALU_BR    = 3'b100;
    localparam logic [2:0] ALU_SJ    = 3'b101;
    localparam logic [2:0] ALU_JALR  = 3'b110;
    localparam logic [2:0] ALU_AUIPC = 3'b111;

    // Moore part of the control word; the FETCH-time PC/IR writes are added separately.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC: legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic state_t dispatch(input logic [6:0] op);
        state_t s;
        case (op)
            OP_R:               s = S_EXEC_R;
            OP_I:               s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            OP_JAL:             s = S_JAL;
            OP_JALR:            s = S_JALR;
            OP_LUI:             s = S_LUI;
            OP_AUIPC:           s = S_AUIPC;
            default:            s = S_FETCH;
        endcase
        return s;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.iord      = 1'b0;
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALU_R;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_I;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_ALUOUT;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_LW;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = SRC_A_RS1;
                c.alu_src_b     = SRC_B_RS2;
                c.alu_op        = ALU_BR;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_SRC_ALUOUT;
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_PC;
            end
            S_JALR: begin
                c.alu_src_a  = SRC_A_RS1;
                c.alu_src_b  = SRC_B_IMM;
                c.alu_op     = ALU_JALR;
                c.pc_write   = 1'b1;
                c.pc_src     = PC_SRC_JALR;
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_PC;
            end
            S_LUI: begin
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_LUI;
            end
            S_AUIPC: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_AUIPC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int ALU_OP_WIDTH = 3,
    parameter int STATE_WIDTH  = 4
);
    logic [6:0]              OP_i;
    logic                    Zero_i;
    logic                    Mem_Ready_i;
    logic                    PC_Write_o;
    logic                    PC_Write_Cond_o;
    logic                    IorD_o;
    logic                    IR_Write_o;
    logic                    Mem_Read_o;
    logic                    Mem_Write_o;
    logic                    Reg_Write_o;
    logic [1:0]              Mem_to_Reg_o;
    logic [1:0]              ALU_Src_A_o;
    logic [1:0]              ALU_Src_B_o;
    logic [ALU_OP_WIDTH-1:0] ALU_Op_o;
    logic [1:0]              PC_Src_o;
    logic                    Illegal_o;
    logic [STATE_WIDTH-1:0]  State_o;

    modport master (
        input  OP_i, Zero_i, Mem_Ready_i,
        output PC_Write_o, PC_Write_Cond_o, IorD_o, IR_Write_o, Mem_Read_o,
               Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o,
               ALU_Op_o, PC_Src_o, Illegal_o, State_o
    );

    modport slave (
        output OP_i, Zero_i, Mem_Ready_i,
        input  PC_Write_o, PC_Write_Cond_o, IorD_o, IR_Write_o, Mem_Read_o,
               Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o,
               ALU_Op_o, PC_Src_o, Illegal_o, State_o
    );

endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: state register, next-state logic and registered
// Moore control word; FETCH PC/IR writes and the illegal flag are qualified live.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_WIDTH  = 3,
    parameter int STATE_WIDTH   = 4,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic   mem_ready;
    logic   fetch_done;

    generate
        if (MEM_HANDSHAKE != 0) begin : g_handshake
            assign mem_ready = bus.Mem_Ready_i;
        end else begin : g_no_handshake
            assign mem_ready = 1'b1;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE:   state_next = dispatch(bus.OP_i);
            S_EXEC_R,
            S_EXEC_I,
            S_LUI,
            S_AUIPC:    state_next = S_ALU_WB;
            S_MEM_ADDR: state_next = (bus.OP_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_ALU_WB,
            S_MEM_WB,
            S_BRANCH,
            S_JAL,
            S_JALR:     state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // The control word is decoded from the next state so it lines up with state_reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            ctrl_reg  <= decode_ctrl(S_FETCH);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode_ctrl(state_next);
        end
    end

    // Gated by reset so no PC/IR write can leak out while reset is held.
    assign fetch_done = (state_reg == S_FETCH) && mem_ready && reset;

    assign bus.PC_Write_o      = ctrl_reg.pc_write | fetch_done;
    assign bus.IR_Write_o      = fetch_done;
    assign bus.PC_Write_Cond_o = ctrl_reg.pc_write_cond;
    assign bus.IorD_o          = ctrl_reg.iord;
    assign bus.Mem_Read_o      = ctrl_reg.mem_read;
    assign bus.Mem_Write_o     = ctrl_reg.mem_write;
    assign bus.Reg_Write_o     = ctrl_reg.reg_write;
    assign bus.Mem_to_Reg_o    = ctrl_reg.mem_to_reg;
    assign bus.ALU_Src_A_o     = ctrl_reg.alu_src_a;
    assign bus.ALU_Src_B_o     = ctrl_reg.alu_src_b;
    assign bus.ALU_Op_o        = ALU_OP_WIDTH'(ctrl_reg.alu_op);
    assign bus.PC_Src_o        = ctrl_reg.pc_src;
    assign bus.Illegal_o       = (state_reg == S_DECODE) && !is_legal(bus.OP_i);
    assign bus.State_o         = STATE_WIDTH'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus queues a hand-written expected control word per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic [1:0] m2r;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic [1:0] psrc;
        logic       ill;
    } exp_t;

    // Field order: st pcw pcwc iord irw mrd mwr rw m2r sa sb op psrc ill
    localparam exp_t E_FETCH_GO    = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_FETCH_STALL = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_DECODE      = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_DECODE_ILL  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b1};
    localparam exp_t E_EXEC_R      = '{4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_EXEC_I      = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd1, 2'd0, 1'b0};
    localparam exp_t E_ALU_WB      = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_MEM_ADDR    = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd3, 2'd0, 1'b0};
    localparam exp_t E_MEM_RD      = '{4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_MEM_WB      = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_MEM_WR      = '{4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam exp_t E_BRANCH      = '{4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd4, 2'd1, 1'b0};
    localparam exp_t E_JAL         = '{4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0};
    localparam exp_t E_JALR        = '{4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 3'd6, 2'd2, 1'b0};
    localparam exp_t E_LUI         = '{4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 3'd2, 2'd0, 1'b0};
    localparam exp_t E_AUIPC       = '{4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd7, 2'd0, 1'b0};

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    string name_q[$];

    multicycle_control_if #(.ALU_OP_WIDTH(3), .STATE_WIDTH(4)) bus ();

    multicycle_control #(
        .ALU_OP_WIDTH (3),
        .STATE_WIDTH  (4),
        .MEM_HANDSHAKE(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sample_dut();
        exp_t a;
        a.st   = bus.State_o;
        a.pcw  = bus.PC_Write_o;
        a.pcwc = bus.PC_Write_Cond_o;
        a.iord = bus.IorD_o;
        a.irw  = bus.IR_Write_o;
        a.mrd  = bus.Mem_Read_o;
        a.mwr  = bus.Mem_Write_o;
        a.rw   = bus.Reg_Write_o;
        a.m2r  = bus.Mem_to_Reg_o;
        a.sa   = bus.ALU_Src_A_o;
        a.sb   = bus.ALU_Src_B_o;
        a.op   = bus.ALU_Op_o;
        a.psrc = bus.PC_Src_o;
        a.ill  = bus.Illegal_o;
        return a;
    endfunction

    // Monitor: one comparison per queued cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s actual=%h required=%h (st %0d vs %0d)", n, a, e, a.st, e.st);
            end
        end
    end

    task automatic cycle(input string name, input logic [6:0] op, input logic rdy,
                         input logic zero, input exp_t e);
        bus.OP_i        = op;
        bus.Mem_Ready_i = rdy;
        bus.Zero_i      = zero;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        bus.OP_i        = 7'h00;
        bus.Mem_Ready_i = 1'b1;
        bus.Zero_i      = 1'b0;

        @(posedge clk);
        #1;
        exp_q.push_back(E_FETCH_STALL);
        name_q.push_back("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;

        cycle("r_fetch",  OP_R, 1'b1, 1'b0, E_FETCH_GO);
        cycle("r_decode", OP_R, 1'b1, 1'b0, E_DECODE);
        cycle("r_exec",   OP_R, 1'b1, 1'b0, E_EXEC_R);
        cycle("r_wb",     OP_R, 1'b1, 1'b0, E_ALU_WB);
        $display("TXN R-type 0x33 issued (4 cycles)");

        cycle("lw_fetch",  OP_LOAD, 1'b1, 1'b0, E_FETCH_GO);
        cycle("lw_decode", OP_LOAD, 1'b1, 1'b0, E_DECODE);
        cycle("lw_addr",   OP_LOAD, 1'b1, 1'b0, E_MEM_ADDR);
        cycle("lw_rd_s1",  OP_LOAD, 1'b0, 1'b0, E_MEM_RD);
        cycle("lw_rd_s2",  OP_LOAD, 1'b0, 1'b0, E_MEM_RD);
        cycle("lw_rd_go",  OP_LOAD, 1'b1, 1'b0, E_MEM_RD);
        cycle("lw_wb",     OP_LOAD, 1'b1, 1'b0, E_MEM_WB);
        $display("TXN LW 0x03 issued with 2 wait states (7 cycles)");

        cycle("fs_stall1", OP_I, 1'b0, 1'b0, E_FETCH_STALL);
        cycle("fs_stall2", OP_I, 1'b0, 1'b0, E_FETCH_STALL);
        cycle("fs_stall3", OP_I, 1'b0, 1'b0, E_FETCH_STALL);
        cycle("fs_go",     OP_I, 1'b1, 1'b0, E_FETCH_GO);
        cycle("i_decode",  OP_I, 1'b1, 1'b0, E_DECODE);
        cycle("i_exec",    OP_I, 1'b1, 1'b0, E_EXEC_I);
        cycle("i_wb",      OP_I, 1'b1, 1'b0, E_ALU_WB);
        $display("TXN I-type 0x13 issued after 3-cycle fetch stall");

        cycle("beq1_fetch",  OP_BRANCH, 1'b1, 1'b1, E_FETCH_GO);
        cycle("beq1_decode", OP_BRANCH, 1'b1, 1'b1, E_DECODE);
        cycle("beq1_br",     OP_BRANCH, 1'b1, 1'b1, E_BRANCH);
        $display("TXN BEQ 0x63 Zero=1 issued (3 cycles)");
        cycle("beq0_fetch",  OP_BRANCH, 1'b1, 1'b0, E_FETCH_GO);
        cycle("beq0_decode", OP_BRANCH, 1'b1, 1'b0, E_DECODE);
        cycle("beq0_br",     OP_BRANCH, 1'b1, 1'b0, E_BRANCH);
        $display("TXN BEQ 0x63 Zero=0 issued (3 cycles)");

        cycle("ill_fetch",  7'h7F, 1'b1, 1'b0, E_FETCH_GO);
        cycle("ill_decode", 7'h7F, 1'b1, 1'b0, E_DECODE_ILL);
        $display("TXN illegal 0x7F issued (2 cycles)");

        cycle("jal_fetch",  OP_JAL, 1'b1, 1'b0, E_FETCH_GO);
        cycle("jal_decode", OP_JAL, 1'b1, 1'b0, E_DECODE);
        cycle("jal_exec",   OP_JAL, 1'b1, 1'b0, E_JAL);
        $display("TXN JAL 0x6F issued (3 cycles)");

        cycle("jalr_fetch",  OP_JALR, 1'b1, 1'b0, E_FETCH_GO);
        cycle("jalr_decode", OP_JALR, 1'b1, 1'b0, E_DECODE);
        cycle("jalr_exec",   OP_JALR, 1'b1, 1'b0, E_JALR);
        $display("TXN JALR 0x67 issued (3 cycles)");

        cycle("lui_fetch",  OP_LUI, 1'b1, 1'b0, E_FETCH_GO);
        cycle("lui_decode", OP_LUI, 1'b1, 1'b0, E_DECODE);
        cycle("lui_exec",   OP_LUI, 1'b1, 1'b0, E_LUI);
        cycle("lui_wb",     OP_LUI, 1'b1, 1'b0, E_ALU_WB);
        $display("TXN LUI 0x37 issued (4 cycles)");

        cycle("auipc_fetch",  OP_AUIPC, 1'b1, 1'b0, E_FETCH_GO);
        cycle("auipc_decode", OP_AUIPC, 1'b1, 1'b0, E_DECODE);
        cycle("auipc_exec",   OP_AUIPC, 1'b1, 1'b0, E_AUIPC);
        cycle("auipc_wb",     OP_AUIPC, 1'b1, 1'b0, E_ALU_WB);
        $display("TXN AUIPC 0x17 issued (4 cycles)");

        cycle("sw_fetch",  OP_STORE, 1'b1, 1'b0, E_FETCH_GO);
        cycle("sw_decode", OP_STORE, 1'b1, 1'b0, E_DECODE);
        cycle("sw_addr",   OP_STORE, 1'b1, 1'b0, E_MEM_ADDR);
        cycle("sw_wr",     OP_STORE, 1'b1, 1'b0, E_MEM_WR);
        $display("TXN SW 0x23 issued (4 cycles)");

        // Store that stalls, then reset asserted asynchronously mid-stall.
        cycle("sw2_fetch",  OP_STORE, 1'b1, 1'b0, E_FETCH_GO);
        cycle("sw2_decode", OP_STORE, 1'b1, 1'b0, E_DECODE);
        cycle("sw2_addr",   OP_STORE, 1'b1, 1'b0, E_MEM_ADDR);
        cycle("sw2_stall1", OP_STORE, 1'b0, 1'b0, E_MEM_WR);
        bus.Mem_Ready_i = 1'b0;
        exp_q.push_back(E_MEM_WR);
        name_q.push_back("sw2_stall2");
        #6;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.State_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_state actual=%0d required=0", bus.State_o);
        end
        checks++;
        if (bus.Mem_Write_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mem_write actual=%b required=0", bus.Mem_Write_o);
        end
        @(posedge clk);
        #1;
        bus.Mem_Ready_i = 1'b1;
        exp_q.push_back(E_FETCH_STALL);
        name_q.push_back("reset_mid_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("TXN SW 0x23 aborted by asynchronous reset during write stall");

        cycle("post_fetch",  OP_R, 1'b1, 1'b0, E_FETCH_GO);
        cycle("post_decode", OP_R, 1'b1, 1'b0, E_DECODE);
        cycle("post_exec",   OP_R, 1'b1, 1'b0, E_EXEC_R);
        cycle("post_wb",     OP_R, 1'b1, 1'b0, E_ALU_WB);
        $display("TXN R-type 0x33 issued after reset recovery");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
